handshake_requester: RTL and testbench
======================================

# handshake_requester

Single-clock master-side requester for the team's 4-phase sync/ack handshake. It accepts request words from a valid/ready stream, drives `sync`/`data_out` toward a handshake slave, and captures the slave's `data_in` when `ack` rises. It then returns the result on a one-entry valid/ready response stream. It sits between a streaming producer/consumer and any slave that computes a response from the request word.

## Interface
- `WIDTH`, 32, request and response word width
- `TIMEOUT_CYCLES`, 1024, max cycles in REQ without `ack` (used only with timeout feature)
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high
- `req_valid`  in  1  request word present
- `req_ready`  out  1  request accepted when both high
- `req_data`  in  WIDTH  request word
- `sync`  out  1  handshake request to slave
- `ack`  in  1  handshake acknowledge from slave, same clock domain
- `data_out`  out  WIDTH  word presented to slave
- `data_in`  in  WIDTH  slave response, valid while `ack`=1
- `rsp_valid`  out  1  response held
- `rsp_ready`  in  1  consumer takes response when both high
- `rsp_data`  out  WIDTH  captured response
- `rsp_error`  out  1  response produced by timeout

## Operation
- States: IDLE, REQ, REL.
- Reset values: state IDLE, `sync`=0, `data_out`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_error`=0, timeout counter 0.
- `req_ready` = (state==IDLE) && !`rsp_valid` && !`ack` (combinational).
- IDLE: on `req_valid`&&`req_ready`, load `data_out`<=`req_data`, `sync`<=1, go REQ.
- REQ: hold `sync`=1 and `data_out` stable. When `ack`=1: `rsp_data`<=`data_in`, `rsp_error`<=0, `rsp_valid`<=1, `sync`<=0, go REL.
- REL: `sync`=0. When `ack`=0, go IDLE.
- Response register: `rsp_valid` clears on `rsp_valid`&&`rsp_ready` in any state. It is never overwritten while valid, which the `req_ready` gating guarantees.
- `ack`=1 observed in IDLE (late or spurious): no action, request acceptance stalls until `ack`=0.
- Reset mid-transaction: `sync` drops next edge, the response is discarded, and no cleanup with the slave is required beyond the `ack`=0 gate on `req_ready`.

## Timing
- Accept at edge N → `sync`=1, `data_out` valid from N+1.
- `ack` first sampled high at edge M → `rsp_valid`=1 and `sync`=0 from M+1.
- `ack` sampled low at edge P (P>M) → IDLE from P+1. Minimum 1 cycle in REL.
- Minimum request-to-request period with a 1-cycle-responsive slave and `rsp_ready` tied high: 4 cycles.
- Response may be consumed during REL. The earliest next accept is the cycle IDLE is entered with `rsp_valid`=0.

## Configuration
- `HS_TIMEOUT_EN` defined: in REQ a counter increments each cycle with `ack`=0.
  - On reaching `TIMEOUT_CYCLES`-1 without `ack`: `sync`<=0, `rsp_data`<=0, `rsp_error`<=1, `rsp_valid`<=1, go REL.
  - Counter clears on entering REQ.
  - Counter width is $clog2(`TIMEOUT_CYCLES`).
  - `ack` arriving on the same edge as expiry wins: normal response.
- `HS_TIMEOUT_EN` undefined: no counter, REQ waits indefinitely, `rsp_error` tied 0.

## Structure
- Shared package `hs_pkg`: state encoding (IDLE=2'd0, REQ=2'd1, REL=2'd2), default `WIDTH` constant. All handshake blocks use these.
- One sub-module: `hs_timeout_counter` (clear, enable, expire pulse), instantiated only under `HS_TIMEOUT_EN`.

## Test plan
- Reset, then `req_data`=0xDEADBEEF; slave acks 3 cycles after `sync` with `data_in`=0x12345678 → `rsp_data`=0x12345678, `rsp_error`=0, `sync` high exactly 4 cycles, `data_out` stable throughout.
- `rsp_ready`=0 for 10 cycles after a response → `req_ready` stays 0, second request not accepted, `rsp_data` unchanged, then drains on `rsp_ready`=1.
- Back-to-back 16 requests with 1-cycle slave and `rsp_ready`=1 → 16 responses in order, 4-cycle period each.
- Slave holds `ack` high 5 cycles after `sync` falls → state stays REL, no new `sync` until `ack`=0.
- `reset` asserted while in REQ → next cycle `sync`=0, `rsp_valid`=0. With `ack`=1 lingering, `req_ready`=0 until `ack` drops.
- With `HS_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, slave never acks → `rsp_valid`=1, `rsp_error`=1, `rsp_data`=0 eight cycles after `sync` rise. A late `ack` pulse then blocks `req_ready`.

Source files
------------

// File: rtl/hs_pkg.sv
// Shared definitions for the sync/ack handshake blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hs_pkg;

  // Default request/response word width for handshake blocks.
  localparam int unsigned HS_WIDTH = 32;

  // Handshake requester state encoding, shared by every handshake block.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } hs_state_e;

endpackage

// File: rtl/hs_timeout_counter.sv
// Cycle counter that flags when a handshake has waited too long for ack.
// Latency: expire_o is combinational on the cycle the count reaches TIMEOUT_CYCLES-1.
// Backpressure: none; counts only while enable_i is high, holds otherwise.
//
// Ports:
//   clock, reset  sole clock and synchronous active-high reset
//   clear_i       forces the count back to zero (takes priority over enable_i)
//   enable_i      advance the count this cycle
//   expire_o      high while enabled and the count sits at its last value
module hs_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  // A one-cycle timeout still needs a one-bit register.
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire_o = enable_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expire_o) begin
      // Stop at LAST so a non-power-of-two limit never wraps.
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/handshake_requester.sv
// Master-side 4-phase sync/ack requester bridging a request stream to a handshake slave.
// Latency: accept->sync 1 cycle; ack->rsp_valid 1 cycle; 4-cycle minimum request period.
// Backpressure: req_ready drops while busy, while a response is unconsumed, or while ack is high.
//
// Optional feature: define HS_TIMEOUT_EN to abort a request that waits TIMEOUT_CYCLES
// without ack; the aborted request returns rsp_data=0 with rsp_error=1.
//
// Ports:
//   clock, reset                    sole clock, synchronous active-high reset
//   req_valid/req_ready/req_data    request stream in
//   sync/data_out                   handshake request and word toward the slave
//   ack/data_in                     slave acknowledge and response word
//   rsp_valid/rsp_ready/rsp_data    one-entry response stream out
//   rsp_error                       response was produced by a timeout
module handshake_requester
  import hs_pkg::*;
#(
  parameter int unsigned WIDTH          = HS_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  output logic             sync,
  input  logic             ack,
  output logic [WIDTH-1:0] data_out,
  input  logic [WIDTH-1:0] data_in,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_error
);

  hs_state_e        state_q, state_d;
  logic             sync_q, sync_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_error_q, rsp_error_d;
  logic             timeout_expire;

`ifdef HS_TIMEOUT_EN
  // Count only ack-less REQ cycles; holding clear outside REQ means the
  // count is zero whenever REQ is entered.
  hs_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear_i (state_q != REQ),
    .enable_i((state_q == REQ) && !ack),
    .expire_o(timeout_expire)
  );
`else
  // Without the timeout, REQ waits for ack indefinitely.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout_expire     = 1'b0;
`endif

  // A lingering ack in IDLE belongs to the previous (or an aborted) transaction;
  // starting a new one before it drops would confuse the slave's 4-phase sequence.
  assign req_ready = (state_q == IDLE) && !rsp_valid_q && !ack;

  assign sync      = sync_q;
  assign data_out  = data_out_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_error = rsp_error_q;

  always_comb begin
    state_d     = state_q;
    sync_d      = sync_q;
    data_out_d  = data_out_q;
    // Consumption can happen in any state; req_ready gating guarantees the
    // register is empty before a new response can be written below.
    rsp_valid_d = rsp_valid_q && !rsp_ready;
    rsp_data_d  = rsp_data_q;
    rsp_error_d = rsp_error_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          data_out_d = req_data;
          sync_d     = 1'b1;
          state_d    = REQ;
        end
      end
      REQ: begin
        // ack wins over a timeout expiring on the same edge.
        if (ack) begin
          rsp_data_d  = data_in;
          rsp_error_d = 1'b0;
          rsp_valid_d = 1'b1;
          sync_d      = 1'b0;
          state_d     = REL;
        end else if (timeout_expire) begin
          rsp_data_d  = '0;
          rsp_error_d = 1'b1;
          rsp_valid_d = 1'b1;
          sync_d      = 1'b0;
          state_d     = REL;
        end
      end
      REL: begin
        sync_d = 1'b0;
        if (!ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        sync_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      sync_q      <= 1'b0;
      data_out_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      data_out_q  <= data_out_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
    end
  end

endmodule

// File: tb/tb_handshake_requester.sv
// Directed self-checking bench for handshake_requester.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_handshake_requester;

  localparam int unsigned W = 32;
  localparam logic [31:0] B2B_BASE = 32'h0000_1000;
  localparam logic [31:0] B2B_KEY  = 32'hA5A5_0F0F;

  logic          clock;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [W-1:0]  req_data;
  logic          sync;
  logic          ack;
  logic [W-1:0]  data_out;
  logic [W-1:0]  data_in;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_data;
  logic          rsp_error;

  int checks;
  int failures;

  handshake_requester #(
    .WIDTH         (W),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_data (req_data),
    .sync     (sync),
    .ack      (ack),
    .data_out (data_out),
    .data_in  (data_in),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_error(rsp_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_data = '0; ack = 1'b0;
    data_in = '0; rsp_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    #1;
    checks++; if (sync !== 1'b0) begin failures++; $display("FAIL reset_sync got=%b exp=0", sync); end
    checks++; if (data_out !== 32'h0) begin failures++; $display("FAIL reset_data_out got=%h exp=0", data_out); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_data !== 32'h0) begin failures++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    checks++; if (rsp_error !== 1'b0) begin failures++; $display("FAIL reset_rsp_error got=%b exp=0", rsp_error); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
  endtask

  // Slave acks on the 4th cycle of sync, so sync must be high exactly 4 cycles.
  task automatic test_single();
    req_valid = 1'b1; req_data = 32'hDEAD_BEEF;
    step();
    req_valid = 1'b0; req_data = 32'h0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (sync !== 1'b1) begin failures++; $display("FAIL single_sync_high cyc=%0d got=%b exp=1", i, sync); end
      checks++; if (data_out !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_data_out cyc=%0d got=%h exp=deadbeef", i, data_out); end
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_early_rsp cyc=%0d got=%b exp=0", i, rsp_valid); end
      if (i == 3) begin ack = 1'b1; data_in = 32'h1234_5678; end
      step();
    end
    checks++; if (sync !== 1'b0) begin failures++; $display("FAIL single_sync_fall got=%b exp=0", sync); end
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL single_rsp_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_data !== 32'h1234_5678) begin failures++; $display("FAIL single_rsp_data got=%h exp=12345678", rsp_data); end
    checks++; if (rsp_error !== 1'b0) begin failures++; $display("FAIL single_rsp_error got=%b exp=0", rsp_error); end
    ack = 1'b0; data_in = 32'h0;
    step();
  endtask

  // Response left unconsumed for 10 cycles must block a waiting request.
  task automatic test_backpressure();
    req_valid = 1'b1; req_data = 32'hCAFE_F00D;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL bp_req_ready cyc=%0d got=%b exp=0", i, req_ready); end
      checks++; if (sync !== 1'b0) begin failures++; $display("FAIL bp_sync cyc=%0d got=%b exp=0", i, sync); end
      checks++; if (rsp_data !== 32'h1234_5678) begin failures++; $display("FAIL bp_rsp_data cyc=%0d got=%h exp=12345678", i, rsp_data); end
      step();
    end
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_rsp_held got=%b exp=1", rsp_valid); end
    rsp_ready = 1'b1;
    step();
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", rsp_valid); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after_drain got=%b exp=1", req_ready); end
    step();
    req_valid = 1'b0;
    checks++; if (sync !== 1'b1) begin failures++; $display("FAIL bp_second_sync got=%b exp=1", sync); end
    checks++; if (data_out !== 32'hCAFE_F00D) begin failures++; $display("FAIL bp_second_data got=%h exp=cafef00d", data_out); end
  endtask

  // Slave keeps ack high 5 cycles after sync falls; no new request may start.
  task automatic test_ack_hold();
    ack = 1'b1; data_in = 32'h0BAD_CAFE;
    step();
    checks++; if (rsp_data !== 32'h0BAD_CAFE) begin failures++; $display("FAIL hold_rsp_data got=%h exp=0badcafe", rsp_data); end
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL hold_rsp_valid got=%b exp=1", rsp_valid); end
    req_valid = 1'b1; req_data = 32'h1111_2222;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (sync !== 1'b0) begin failures++; $display("FAIL hold_sync cyc=%0d got=%b exp=0", i, sync); end
      checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL hold_req_ready cyc=%0d got=%b exp=0", i, req_ready); end
      step();
    end
    ack = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL hold_still_rel got=%b exp=0", req_ready); end
    step();
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL hold_idle_ready got=%b exp=1", req_ready); end
    checks++; if (sync !== 1'b0) begin failures++; $display("FAIL hold_idle_sync got=%b exp=0", sync); end
    step();
    req_valid = 1'b0;
    checks++; if (sync !== 1'b1) begin failures++; $display("FAIL hold_next_sync got=%b exp=1", sync); end
    checks++; if (data_out !== 32'h1111_2222) begin failures++; $display("FAIL hold_next_data got=%h exp=11112222", data_out); end
  endtask

  // Reset lands while in REQ with ack arriving; ack lingering afterwards gates req_ready.
  task automatic test_reset_mid();
    reset = 1'b1; ack = 1'b1; data_in = 32'h7777_7777;
    step();
    reset = 1'b0;
    checks++; if (sync !== 1'b0) begin failures++; $display("FAIL rstmid_sync got=%b exp=0", sync); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rstmid_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (data_out !== 32'h0) begin failures++; $display("FAIL rstmid_data_out got=%h exp=0", data_out); end
    #1;
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rstmid_ready_ack got=%b exp=0", req_ready); end
    step();
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rstmid_ready_ack2 got=%b exp=0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rstmid_no_rsp got=%b exp=0", rsp_valid); end
    ack = 1'b0; data_in = 32'h0;
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready_free got=%b exp=1", req_ready); end
    step();
  endtask

  // 16 requests; slave raises ack one cycle after seeing sync and drops it as soon
  // as sync falls. Responses must come back in order, 4 cycles apart.
  task automatic test_back_to_back();
    logic        prev_sync;
    logic        acc;
    logic [31:0] exp_d;
    int          sent;
    int          got;
    int          cyc;
    int          last_cyc;
    prev_sync = 1'b0; ack = 1'b0; rsp_ready = 1'b1;
    sent = 0; got = 0; cyc = 0; last_cyc = 0;
    req_valid = 1'b1; req_data = B2B_BASE;
    #1;
    acc = req_valid && req_ready;
    while (got < 16 && cyc < 200) begin
      step();
      cyc++;
      if (acc) begin
        sent++;
        if (sent == 16) req_valid = 1'b0;
        else req_data = B2B_BASE + 32'(sent);
      end
      if (rsp_valid === 1'b1) begin
        exp_d = (B2B_BASE + 32'(got)) ^ B2B_KEY;
        checks++; if (rsp_data !== exp_d) begin failures++; $display("FAIL b2b_data idx=%0d got=%h exp=%h", got, rsp_data, exp_d); end
        checks++; if (rsp_error !== 1'b0) begin failures++; $display("FAIL b2b_error idx=%0d got=%b exp=0", got, rsp_error); end
        if (got > 0) begin
          checks++; if (cyc - last_cyc != 4) begin failures++; $display("FAIL b2b_period idx=%0d got=%0d exp=4", got, cyc - last_cyc); end
        end
        last_cyc = cyc;
        got++;
      end
      ack = prev_sync && sync;
      data_in = data_out ^ B2B_KEY;
      prev_sync = sync;
      #1;
      acc = req_valid && req_ready;
    end
    checks++; if (got != 16) begin failures++; $display("FAIL b2b_count got=%0d exp=16", got); end
    checks++; if (sent != 16) begin failures++; $display("FAIL b2b_sent got=%0d exp=16", sent); end
    ack = 1'b0; req_valid = 1'b0;
    step(); step();
  endtask

`ifdef HS_TIMEOUT_EN
  // TIMEOUT_CYCLES=8, no ack: error response 8 cycles after sync rises.
  task automatic test_timeout();
    rsp_ready = 1'b0; ack = 1'b0;
    req_valid = 1'b1; req_data = 32'h55AA_55AA;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL to_early cyc=%0d got=%b exp=0", i, rsp_valid); end
      checks++; if (sync !== 1'b1) begin failures++; $display("FAIL to_sync cyc=%0d got=%b exp=1", i, sync); end
      step();
    end
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL to_rsp_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_error !== 1'b1) begin failures++; $display("FAIL to_rsp_error got=%b exp=1", rsp_error); end
    checks++; if (rsp_data !== 32'h0) begin failures++; $display("FAIL to_rsp_data got=%h exp=0", rsp_data); end
    checks++; if (sync !== 1'b0) begin failures++; $display("FAIL to_sync_fall got=%b exp=0", sync); end
    rsp_ready = 1'b1;
    step();
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL to_idle_ready got=%b exp=1", req_ready); end
    ack = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL to_late_ack got=%b exp=0", req_ready); end
    step();
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL to_late_ack2 got=%b exp=0", req_ready); end
    checks++; if (sync !== 1'b0) begin failures++; $display("FAIL to_late_sync got=%b exp=0", sync); end
    ack = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL to_ack_gone got=%b exp=1", req_ready); end
    step();
  endtask
`else
  // Without the timeout a silent slave leaves the request pending well past 8 cycles.
  task automatic test_no_timeout();
    rsp_ready = 1'b1; ack = 1'b0;
    req_valid = 1'b1; req_data = 32'h55AA_55AA;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL nto_rsp cyc=%0d got=%b exp=0", i, rsp_valid); end
      checks++; if (sync !== 1'b1) begin failures++; $display("FAIL nto_sync cyc=%0d got=%b exp=1", i, sync); end
      step();
    end
    rsp_ready = 1'b0; ack = 1'b1; data_in = 32'h3C3C_3C3C;
    step();
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL nto_rsp_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_error !== 1'b0) begin failures++; $display("FAIL nto_rsp_error got=%b exp=0", rsp_error); end
    checks++; if (rsp_data !== 32'h3C3C_3C3C) begin failures++; $display("FAIL nto_rsp_data got=%h exp=3c3c3c3c", rsp_data); end
    ack = 1'b0; rsp_ready = 1'b1;
    step(); step();
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single();
    test_backpressure();
    test_ack_hold();
    test_reset_mid();
    test_back_to_back();
`ifdef HS_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
